// File: rtl/x_corr_lag_feeder_if.sv
// Load-side and stream-side signals of the cross-correlator lag feeder.
// The slave modport is the feeder's view; the master modport drives it.
interface x_corr_lag_feeder_if #(
  parameter int xi_bits             = 12,
  parameter int xq_bits             = 12,
  parameter int yi_bits             = 12,
  parameter int yq_bits             = 12,
  parameter int length_counter_bits = 3
);
  logic                           m_axis_tvalid;
  logic                           s_axis_tready;
  logic [xi_bits-1:0]             xi_in;
  logic [xq_bits-1:0]             xq_in;
  logic [yi_bits-1:0]             yi_in;
  logic [yq_bits-1:0]             yq_in;
  logic [xi_bits-1:0]             xi;
  logic [xq_bits-1:0]             xq;
  logic [yi_bits-1:0]             yi;
  logic [yq_bits-1:0]             yq;
  logic [length_counter_bits-1:0] lag;
  logic                           last;
  logic                           s_axis_tvalid;
  logic                           m_axis_tready;

  modport slave (
    input  m_axis_tvalid, xi_in, xq_in, yi_in, yq_in, m_axis_tready,
    output s_axis_tready, xi, xq, yi, yq, lag, last, s_axis_tvalid
  );

  modport master (
    output m_axis_tvalid, xi_in, xq_in, yi_in, yq_in, m_axis_tready,
    input  s_axis_tready, xi, xq, yi, yq, lag, last, s_axis_tvalid
  );
endinterface

// File: rtl/x_corr_lag_feeder.sv
// Buffers length x samples and 2*length y samples, then streams (x[n], y[lag+n])
// for lag = 0..length, n = 0..length-1, one pair per accepted beat.
module x_corr_lag_feeder #(
  parameter int xi_bits             = 12,
  parameter int xq_bits             = 12,
  parameter int yi_bits             = 12,
  parameter int yq_bits             = 12,
  parameter int length              = 5,
  parameter int length_counter_bits = 3,
  parameter int addr_bits           = 4
) (
  input logic              clk,
  input logic              rst,
  x_corr_lag_feeder_if.slave bus
);
  typedef enum logic [1:0] {S_LOAD, S_PRIME, S_STREAM} state_t;

  localparam int YDEPTH = 2 * length;
  localparam logic [addr_bits-1:0]           LD_LAST  = addr_bits'(YDEPTH - 1);
  localparam logic [addr_bits-1:0]           X_LIM    = addr_bits'(length);
  localparam logic [length_counter_bits-1:0] N_LAST   = length_counter_bits'(length - 1);
  localparam logic [length_counter_bits-1:0] LAG_LAST = length_counter_bits'(length);

  state_t r_state, w_state_nxt;

  logic [xi_bits-1:0] r_xi_mem [length];
  logic [xq_bits-1:0] r_xq_mem [length];
  logic [yi_bits-1:0] r_yi_mem [YDEPTH];
  logic [yq_bits-1:0] r_yq_mem [YDEPTH];

  logic [addr_bits-1:0]           r_ld_cnt;
  logic [length_counter_bits-1:0] r_n, r_lag;
  logic [xi_bits-1:0]             r_xi;
  logic [xq_bits-1:0]             r_xq;
  logic [yi_bits-1:0]             r_yi;
  logic [yq_bits-1:0]             r_yq;
  logic                           r_last, r_vld;

  logic                           w_acc_ld, w_ld_done, w_acc_out, w_n_wrap, w_end;
  logic [length_counter_bits-1:0] w_nxt_n, w_nxt_lag;
  logic [addr_bits-1:0]           w_nxt_addr;

  assign w_acc_ld   = (r_state == S_LOAD) & bus.m_axis_tvalid;
  assign w_ld_done  = w_acc_ld & (r_ld_cnt == LD_LAST);
  assign w_acc_out  = (r_state == S_STREAM) & r_vld & bus.m_axis_tready;
  assign w_n_wrap   = (r_n == N_LAST);
  assign w_end      = w_n_wrap & (r_lag == LAG_LAST);
  assign w_nxt_n    = w_n_wrap ? '0 : r_n + length_counter_bits'(1);
  assign w_nxt_lag  = w_n_wrap ? r_lag + length_counter_bits'(1) : r_lag;
  // lag+n peaks at 2*length-1, which addr_bits is sized to hold without wrap
  assign w_nxt_addr = addr_bits'(w_nxt_lag) + addr_bits'(w_nxt_n);

  // Ready is held off during the reset cycles themselves, not just after.
  assign bus.s_axis_tready = (r_state == S_LOAD) & ~rst;
  assign bus.s_axis_tvalid = r_vld;
  assign bus.xi            = r_xi;
  assign bus.xq            = r_xq;
  assign bus.yi            = r_yi;
  assign bus.yq            = r_yq;
  assign bus.lag           = r_lag;
  assign bus.last          = r_last;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_LOAD:   if (w_ld_done) w_state_nxt = S_PRIME;
      S_PRIME:  w_state_nxt = S_STREAM;
      S_STREAM: if (w_acc_out && w_end) w_state_nxt = S_LOAD;
      default:  w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_nxt;
  end

  // Sample storage is never reset; a new load overwrites every entry that gets read.
  always_ff @(posedge clk) begin
    if (!rst && w_acc_ld) begin
      r_yi_mem[r_ld_cnt] <= bus.yi_in;
      r_yq_mem[r_ld_cnt] <= bus.yq_in;
      if (r_ld_cnt < X_LIM) begin
        r_xi_mem[length_counter_bits'(r_ld_cnt)] <= bus.xi_in;
        r_xq_mem[length_counter_bits'(r_ld_cnt)] <= bus.xq_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_cnt <= '0;
      r_n      <= '0;
      r_lag    <= '0;
      r_vld    <= 1'b0;
      r_last   <= 1'b0;
      r_xi     <= '0;
      r_xq     <= '0;
      r_yi     <= '0;
      r_yq     <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (w_acc_ld) r_ld_cnt <= w_ld_done ? '0 : r_ld_cnt + addr_bits'(1);
        end
        S_PRIME: begin
          r_n    <= '0;
          r_lag  <= '0;
          r_xi   <= r_xi_mem[0];
          r_xq   <= r_xq_mem[0];
          r_yi   <= r_yi_mem[0];
          r_yq   <= r_yq_mem[0];
          r_last <= (length == 1);
          r_vld  <= 1'b1;
        end
        S_STREAM: begin
          if (w_acc_out) begin
            if (w_end) begin
              r_vld  <= 1'b0;
              r_n    <= '0;
              r_lag  <= '0;
              r_last <= 1'b0;
            end else begin
              r_n    <= w_nxt_n;
              r_lag  <= w_nxt_lag;
              r_xi   <= r_xi_mem[w_nxt_n];
              r_xq   <= r_xq_mem[w_nxt_n];
              r_yi   <= r_yi_mem[w_nxt_addr];
              r_yq   <= r_yq_mem[w_nxt_addr];
              r_last <= (w_nxt_n == N_LAST);
            end
          end
        end
        default: r_vld <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_x_corr_lag_feeder.sv
// Randomized bench for the lag feeder: a sample-capture model generates every
// expected (x[n], y[lag+n], lag, last) beat; a second instance covers length=1.
module tb_x_corr_lag_feeder;
  localparam int L = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  x_corr_lag_feeder_if #(.length_counter_bits(3)) lf_if ();
  x_corr_lag_feeder_if #(.length_counter_bits(1)) lf1_if ();

  x_corr_lag_feeder #(.length(5), .length_counter_bits(3), .addr_bits(4))
    u_dut (.clk(clk), .rst(rst), .bus(lf_if));
  x_corr_lag_feeder #(.length(1), .length_counter_bits(1), .addr_bits(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(lf1_if));

  // stimulus staging and reference model storage
  logic [11:0] st_xi [2*L], st_xq [2*L], st_yi [2*L], st_yq [2*L];
  logic [11:0] xm_i [L], xm_q [L], ym_i [2*L], ym_q [2*L];

  task automatic junk_inputs();
    lf_if.xi_in = 12'($urandom);
    lf_if.xq_in = 12'($urandom);
    lf_if.yi_in = 12'($urandom);
    lf_if.yq_in = 12'($urandom);
  endtask

  task automatic fill_random(input int ybase);
    for (int k = 0; k < 2*L; k++) begin
      st_xi[k] = 12'($urandom);
      st_xq[k] = 12'($urandom);
      st_yi[k] = (ybase < 0) ? 12'($urandom) : 12'(ybase + k);
      st_yq[k] = 12'($urandom);
    end
  endtask

  task automatic load_frame(input int gap, input bit hold);
    for (int k = 0; k < 2*L; k++) begin
      for (int g = 0; g < gap; g++) begin
        lf_if.m_axis_tvalid = 1'b0;
        junk_inputs();
        @(negedge clk);
      end
      lf_if.m_axis_tvalid = 1'b1;
      lf_if.xi_in = st_xi[k];
      lf_if.xq_in = st_xq[k];
      lf_if.yi_in = st_yi[k];
      lf_if.yq_in = st_yq[k];
      n_vec++;
      if (lf_if.s_axis_tready !== 1'b1) begin
        n_err++;
        $display("FAIL load_ready beat %0d: got %b want 1", k, lf_if.s_axis_tready);
      end
      @(negedge clk);
    end
    for (int k = 0; k < L; k++) begin
      xm_i[k] = st_xi[k];
      xm_q[k] = st_xq[k];
    end
    for (int k = 0; k < 2*L; k++) begin
      ym_i[k] = st_yi[k];
      ym_q[k] = st_yq[k];
    end
    lf_if.m_axis_tvalid = hold;
    junk_inputs();
    n_vec++;
    if ({lf_if.s_axis_tvalid, lf_if.s_axis_tready} !== 2'b00) begin
      n_err++;
      $display("FAIL prime_cycle: valid/ready got %b%b want 00",
               lf_if.s_axis_tvalid, lf_if.s_axis_tready);
    end
  endtask

  // mode 0: ready always high, 1: ready 1,0,0,1 repeating, 2: random ready
  task automatic stream_chk(input int mode, input int limit, input bit junk);
    int beat = 0;
    int cyc = 0;
    bit seen = 1'b0;
    bit stalled = 1'b0;
    bit rdy;
    logic [51:0] snap, got, exp;
    while (beat < limit && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      got = {lf_if.xi, lf_if.xq, lf_if.yi, lf_if.yq, lf_if.lag, lf_if.last};
      if (cyc == 1) begin
        n_vec++;
        if (lf_if.s_axis_tvalid !== 1'b1) begin
          n_err++;
          $display("FAIL first_valid_latency: valid got %b want 1", lf_if.s_axis_tvalid);
        end
      end
      if (stalled) begin
        n_vec++;
        if (got !== snap || lf_if.s_axis_tvalid !== 1'b1) begin
          n_err++;
          $display("FAIL stall_hold beat %0d: got %h want %h", beat, got, snap);
        end
      end
      if (mode == 0 && seen) begin
        n_vec++;
        if (lf_if.s_axis_tvalid !== 1'b1) begin
          n_err++;
          $display("FAIL no_bubble beat %0d: valid got %b want 1", beat, lf_if.s_axis_tvalid);
        end
      end
      if (lf_if.s_axis_tvalid === 1'b1) seen = 1'b1;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      lf_if.m_axis_tready = rdy;
      if (junk) begin
        lf_if.m_axis_tvalid = 1'b1;
        junk_inputs();
      end
      if (lf_if.s_axis_tvalid === 1'b1 && rdy) begin
        exp = {xm_i[beat % L], xm_q[beat % L], ym_i[beat / L + beat % L],
               ym_q[beat / L + beat % L], 3'(beat / L), (beat % L == L - 1)};
        n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL beat %0d: got %h want %h", beat, got, exp);
        end
        beat++;
        stalled = 1'b0;
        if (beat == L * (L + 1)) lf_if.m_axis_tvalid = 1'b0;
      end else begin
        stalled = (lf_if.s_axis_tvalid === 1'b1);
        snap = got;
      end
    end
    n_vec++;
    if (beat < limit) begin
      n_err++;
      $display("FAIL stream_timeout: got %0d beats want %0d", beat, limit);
    end
    if (limit == L * (L + 1)) begin
      @(negedge clk);
      lf_if.m_axis_tready = 1'b0;
      n_vec++;
      if ({lf_if.s_axis_tvalid, lf_if.s_axis_tready} !== 2'b01) begin
        n_err++;
        $display("FAIL stream_end: valid/ready got %b%b want 01",
                 lf_if.s_axis_tvalid, lf_if.s_axis_tready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({lf_if.s_axis_tvalid, lf_if.s_axis_tready, lf_if.xi, lf_if.xq, lf_if.yi,
         lf_if.yq, lf_if.lag, lf_if.last} !== 54'd0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b ready=%b lag=%0d last=%b xi=%h yi=%h want all 0",
               lf_if.s_axis_tvalid, lf_if.s_axis_tready, lf_if.lag, lf_if.last, lf_if.xi, lf_if.yi);
    end
    n_vec++;
    if ({lf1_if.s_axis_tvalid, lf1_if.s_axis_tready, lf1_if.lag, lf1_if.last} !== 4'd0) begin
      n_err++;
      $display("FAIL reset_len1: got %b want 0000",
               {lf1_if.s_axis_tvalid, lf1_if.s_axis_tready, lf1_if.lag, lf1_if.last});
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (lf_if.s_axis_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b want 1", lf_if.s_axis_tready);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 2*L; k++) begin
      st_xi[k] = (k < L) ? 12'(k + 1) : 12'($urandom);
      st_xq[k] = (k < L) ? 12'(-(k + 1)) : 12'($urandom);
      st_yi[k] = 12'(10 + k);
      st_yq[k] = 12'd0;
    end
    load_frame(0, 1'b0);
    stream_chk(0, L * (L + 1), 1'b0);
  endtask

  task automatic test_stall();
    load_frame(0, 1'b0);
    stream_chk(1, L * (L + 1), 1'b0);
  endtask

  task automatic test_sparse_load();
    fill_random(-1);
    load_frame(2, 1'b0);
    stream_chk(0, L * (L + 1), 1'b0);
  endtask

  task automatic test_reset_mid();
    fill_random(-1);
    load_frame(0, 1'b0);
    stream_chk(0, 12, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({lf_if.s_axis_tvalid, lf_if.lag, lf_if.last, lf_if.s_axis_tready} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_mid: valid=%b lag=%0d last=%b ready=%b want 0/0/0/0",
               lf_if.s_axis_tvalid, lf_if.lag, lf_if.last, lf_if.s_axis_tready);
    end
    rst = 1'b0;
    lf_if.m_axis_tready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (lf_if.s_axis_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_ready: got %b want 1", lf_if.s_axis_tready);
    end
    fill_random(20);
    load_frame(0, 1'b0);
    stream_chk(0, L * (L + 1), 1'b0);
  endtask

  task automatic test_valid_in_stream();
    fill_random(-1);
    load_frame(1, 1'b1);
    stream_chk(2, L * (L + 1), 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      fill_random(-1);
      load_frame(int'($urandom_range(0, 1)), 1'b0);
      stream_chk(2, L * (L + 1), 1'b0);
    end
  endtask

  task automatic test_len1();
    logic [49:0] exp [2];
    logic [49:0] got;
    int beat = 0;
    exp[0] = {12'd7, 12'h5a5, 12'd3, 12'h0c3, 1'b0, 1'b1};
    exp[1] = {12'd7, 12'h5a5, 12'd4, 12'h3c0, 1'b1, 1'b1};
    lf1_if.m_axis_tready = 1'b0;
    lf1_if.m_axis_tvalid = 1'b1;
    lf1_if.xi_in = 12'd7;  lf1_if.xq_in = 12'h5a5;
    lf1_if.yi_in = 12'd3;  lf1_if.yq_in = 12'h0c3;
    @(negedge clk);
    lf1_if.xi_in = 12'($urandom);  lf1_if.xq_in = 12'($urandom);
    lf1_if.yi_in = 12'd4;  lf1_if.yq_in = 12'h3c0;
    @(negedge clk);
    lf1_if.m_axis_tvalid = 1'b0;
    lf1_if.m_axis_tready = 1'b1;
    for (int c = 0; c < 20 && beat < 2; c++) begin
      @(negedge clk);
      if (lf1_if.s_axis_tvalid === 1'b1) begin
        got = {lf1_if.xi, lf1_if.xq, lf1_if.yi, lf1_if.yq, lf1_if.lag, lf1_if.last};
        n_vec++;
        if (got !== exp[beat]) begin
          n_err++;
          $display("FAIL len1 beat %0d: got %h want %h", beat, got, exp[beat]);
        end
        beat++;
      end
    end
    n_vec++;
    if (beat != 2) begin
      n_err++;
      $display("FAIL len1_timeout: got %0d beats want 2", beat);
    end
    @(negedge clk);
    n_vec++;
    if ({lf1_if.s_axis_tvalid, lf1_if.s_axis_tready} !== 2'b01) begin
      n_err++;
      $display("FAIL len1_end: valid/ready got %b%b want 01",
               lf1_if.s_axis_tvalid, lf1_if.s_axis_tready);
    end
    lf1_if.m_axis_tready = 1'b0;
  endtask

  initial begin
    lf_if.m_axis_tvalid  = 1'b0;
    lf_if.m_axis_tready  = 1'b0;
    lf_if.xi_in = '0; lf_if.xq_in = '0; lf_if.yi_in = '0; lf_if.yq_in = '0;
    lf1_if.m_axis_tvalid = 1'b0;
    lf1_if.m_axis_tready = 1'b0;
    lf1_if.xi_in = '0; lf1_if.xq_in = '0; lf1_if.yi_in = '0; lf1_if.yq_in = '0;
    test_reset();
    test_basic();
    test_stall();
    test_sparse_load();
    test_reset_mid();
    test_valid_in_stream();
    test_back_to_back();
    test_len1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
